// File: rtl/varint_byte_decoder_if.sv
// Byte-stream input and decoded-value FIFO push bundle of the varint byte decoder.
// The master side is the environment; the slave side is the decoder.
interface varint_byte_decoder_if #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 16
);
  logic [7:0]        byte_in_data;
  logic              byte_in_valid;
  logic              byte_in_last;
  logic              byte_in_ready;
  logic              varint_in_fifo_full;
  logic              varint_in_fifo_push;
  logic [DATA_W-1:0] varint_in_fifo_data;
  logic              varint_in_index_push;
  logic [IDX_W-1:0]  varint_in_index_data;

  modport master (
    output byte_in_data, byte_in_valid, byte_in_last, varint_in_fifo_full,
    input  byte_in_ready, varint_in_fifo_push, varint_in_fifo_data,
           varint_in_index_push, varint_in_index_data
  );

  modport slave (
    input  byte_in_data, byte_in_valid, byte_in_last, varint_in_fifo_full,
    output byte_in_ready, varint_in_fifo_push, varint_in_fifo_data,
           varint_in_index_push, varint_in_index_data
  );
endinterface

// File: rtl/varint_byte_decoder.sv
// Strips LEB128 continuation bits from the protobuf wire stream and pushes each
// assembled varint plus its per-message ordinal; overlong/truncated varints are dropped.
module varint_byte_decoder #(
  parameter int DATA_W    = 64,
  parameter int MAX_BYTES = 10,
  parameter int IDX_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  varint_byte_decoder_if.slave   bus,
  output logic                   err_overlong,
  output logic                   err_truncated,
  output logic                   busy
);

  localparam int CNT_W = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    SKIP  = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] acc_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] data_r;
  logic [IDX_W-1:0]  idx_data_r;
  logic              last_r;
  logic              ready_r;
  logic              busy_r;
  logic              err_overlong_r;
  logic              err_truncated_r;
  logic              accept_s;
  logic              cont_s;
  logic              push_s;
  logic [DATA_W-1:0] acc_next_s;

  // Merge the 7-bit payload of byte k at bit 7k; anything above DATA_W falls off.
  function automatic logic [DATA_W-1:0] place_group(
    input logic [DATA_W-1:0] base,
    input logic [6:0]        group,
    input logic [CNT_W-1:0]  k
  );
    logic [DATA_W+6:0] wide;
    logic [6:0]        sh;
    sh   = 7'(k) * 7'd7;
    wide = {{DATA_W{1'b0}}, group} << sh;
    return base | wide[DATA_W-1:0];
  endfunction

  assign accept_s = bus.byte_in_valid && ready_r;
  assign cont_s   = bus.byte_in_data[7];
  // Push must see the FIFO's current full flag, so it is a decode of the EMIT state.
  assign push_s   = (state_r == EMIT) && !bus.varint_in_fifo_full;

  // Next accumulator value: byte 0 starts from an empty accumulator.
  always_comb begin
    acc_next_s = {DATA_W{1'b0}};
    if (cnt_r == {CNT_W{1'b0}}) begin
      acc_next_s = place_group({DATA_W{1'b0}}, bus.byte_in_data[6:0], cnt_r);
    end else begin
      acc_next_s = place_group(acc_r, bus.byte_in_data[6:0], cnt_r);
    end
  end

  // Decoder FSM with its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ACCUM;
      cnt_r           <= {CNT_W{1'b0}};
      acc_r           <= {DATA_W{1'b0}};
      idx_r           <= {IDX_W{1'b0}};
      data_r          <= {DATA_W{1'b0}};
      idx_data_r      <= {IDX_W{1'b0}};
      last_r          <= 1'b0;
      ready_r         <= 1'b1;
      busy_r          <= 1'b0;
      err_overlong_r  <= 1'b0;
      err_truncated_r <= 1'b0;
    end else begin
      err_overlong_r  <= 1'b0;
      err_truncated_r <= 1'b0;
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            if (!cont_s) begin
              data_r     <= acc_next_s;
              idx_data_r <= idx_r;
              last_r     <= bus.byte_in_last;
              acc_r      <= {DATA_W{1'b0}};
              cnt_r      <= {CNT_W{1'b0}};
              state_r    <= EMIT;
              ready_r    <= 1'b0;
              busy_r     <= 1'b1;
            end else if (cnt_r == CNT_W'(MAX_BYTES - 1)) begin
              // Overlong wins over truncation; a final byte also ends the message.
              err_overlong_r <= 1'b1;
              acc_r          <= {DATA_W{1'b0}};
              cnt_r          <= {CNT_W{1'b0}};
              ready_r        <= 1'b1;
              if (bus.byte_in_last) begin
                idx_r   <= {IDX_W{1'b0}};
                state_r <= ACCUM;
                busy_r  <= 1'b0;
              end else begin
                state_r <= SKIP;
                busy_r  <= 1'b1;
              end
            end else if (bus.byte_in_last) begin
              err_truncated_r <= 1'b1;
              acc_r           <= {DATA_W{1'b0}};
              cnt_r           <= {CNT_W{1'b0}};
              idx_r           <= {IDX_W{1'b0}};
              ready_r         <= 1'b1;
              busy_r          <= 1'b0;
            end else begin
              acc_r   <= acc_next_s;
              cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
              ready_r <= 1'b1;
              busy_r  <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (!bus.varint_in_fifo_full) begin
            if (last_r) begin
              idx_r <= {IDX_W{1'b0}};
            end else begin
              idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            state_r <= ACCUM;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        SKIP: begin
          // Discarded varints never consume an ordinal.
          if (accept_s && (bus.byte_in_last || !cont_s)) begin
            if (bus.byte_in_last) begin
              idx_r <= {IDX_W{1'b0}};
            end
            state_r <= ACCUM;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ACCUM;
          cnt_r   <= {CNT_W{1'b0}};
          acc_r   <= {DATA_W{1'b0}};
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_in_ready        = ready_r;
  assign bus.varint_in_fifo_push  = push_s;
  assign bus.varint_in_index_push = push_s;
  assign bus.varint_in_fifo_data  = data_r;
  assign bus.varint_in_index_data = idx_data_r;
  assign err_overlong             = err_overlong_r;
  assign err_truncated            = err_truncated_r;
  assign busy                     = busy_r;

endmodule

// File: tb/tb_varint_byte_decoder.sv
// Scoreboard bench for varint_byte_decoder: expected (value, ordinal) pairs are queued
// as bytes are driven and popped by a monitor whenever the decoder pushes.
module tb_varint_byte_decoder;

  typedef struct packed {
    logic [63:0] data;
    logic [15:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic err_overlong, err_truncated, busy;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ov_cnt = 0;
  int   tr_cnt = 0;

  always #5 clk = ~clk;

  varint_byte_decoder_if #(.DATA_W(64), .IDX_W(16)) bus ();

  varint_byte_decoder #(.DATA_W(64), .MAX_BYTES(10), .IDX_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .err_overlong  (err_overlong),
    .err_truncated (err_truncated),
    .busy          (busy)
  );

  // Monitor: count error pulses and compare every push against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_overlong === 1'b1) ov_cnt++;
      if (err_truncated === 1'b1) tr_cnt++;
      if (bus.varint_in_fifo_push === 1'b1) begin
        exp_t e;
        checks++;
        if (bus.varint_in_index_push !== 1'b1) begin
          errors++;
          $display("FAIL index_push: got %b, expected 1", bus.varint_in_index_push);
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_push: data=%h idx=%0d, expected no push",
                   bus.varint_in_fifo_data, bus.varint_in_index_data);
        end else begin
          e = sb_q.pop_front();
          if (bus.varint_in_fifo_data !== e.data || bus.varint_in_index_data !== e.idx) begin
            errors++;
            $display("FAIL push_value: got data=%h idx=%0d, expected data=%h idx=%0d",
                     bus.varint_in_fifo_data, bus.varint_in_index_data, e.data, e.idx);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input logic [63:0] d, input logic [15:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    sb_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    @(negedge clk);
    bus.byte_in_data  = b;
    bus.byte_in_valid = 1'b1;
    bus.byte_in_last  = last;
    n = 0;
    while (bus.byte_in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL ready_timeout: byte %h not accepted within 100 cycles", b);
    end
    @(posedge clk);
    #1;
    bus.byte_in_valid = 1'b0;
    bus.byte_in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    repeat (3) @(negedge clk);
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d pushes outstanding, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.byte_in_ready !== 1'b1 || bus.varint_in_fifo_push !== 1'b0 || busy !== 1'b0 ||
        err_overlong !== 1'b0 || err_truncated !== 1'b0 ||
        bus.varint_in_fifo_data !== 64'd0 || bus.varint_in_index_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b push=%b busy=%b ov=%b tr=%b data=%h idx=%0d, expected 1,0,0,0,0,0,0",
               bus.byte_in_ready, bus.varint_in_fifo_push, busy, err_overlong, err_truncated,
               bus.varint_in_fifo_data, bus.varint_in_index_data);
    end
  endtask

  task automatic test_basic();
    sb_push(64'd150, 16'd0);
    send_byte(8'h96, 1'b0);
    send_byte(8'h01, 1'b1);
    sb_push(64'd5, 16'd0);
    send_byte(8'h05, 1'b1);
    wait_drain("basic");
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic       lasts [4];
    logic       term  [4];
    bytes = '{8'h00, 8'h7F, 8'hAC, 8'h02};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b1};
    term  = '{1'b1, 1'b1, 1'b0, 1'b1};
    sb_push(64'd0, 16'd0);
    sb_push(64'd127, 16'd1);
    sb_push(64'd300, 16'd2);
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], lasts[i]);
      if (term[i]) begin
        @(negedge clk);
        checks++;
        if (bus.varint_in_fifo_push !== 1'b1) begin
          errors++;
          $display("FAIL push_latency: byte %0d push=%b one cycle after accept, expected 1",
                   i, bus.varint_in_fifo_push);
        end
      end
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_max_len();
    int ov0, tr0;
    ov0 = ov_cnt;
    tr0 = tr_cnt;
    sb_push(64'hFFFF_FFFF_FFFF_FFFF, 16'd0);
    for (int i = 0; i < 9; i++) send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b1);
    sb_push(64'hFFFF_FFFF_FFFF_FFFF, 16'd0);
    for (int i = 0; i < 9; i++) send_byte(8'hFF, 1'b0);
    send_byte(8'h7F, 1'b1);
    wait_drain("max_len");
    checks++;
    if (ov_cnt != ov0 || tr_cnt != tr0) begin
      errors++;
      $display("FAIL max_len_errors: overlong=%0d truncated=%0d new pulses, expected 0,0",
               ov_cnt - ov0, tr_cnt - tr0);
    end
  endtask

  task automatic test_backpressure();
    sb_push(64'd42, 16'd0);
    bus.varint_in_fifo_full = 1'b1;
    send_byte(8'h2A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.byte_in_ready !== 1'b0 || bus.varint_in_fifo_push !== 1'b0 ||
          bus.varint_in_fifo_data !== 64'd42) begin
        errors++;
        $display("FAIL full_hold: cycle %0d ready=%b push=%b data=%h, expected 0,0,2a",
                 i, bus.byte_in_ready, bus.varint_in_fifo_push, bus.varint_in_fifo_data);
      end
    end
    @(posedge clk);
    #1;
    bus.varint_in_fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.varint_in_fifo_push !== 1'b1 || bus.varint_in_fifo_data !== 64'd42) begin
      errors++;
      $display("FAIL full_release: push=%b data=%h, expected 1,2a",
               bus.varint_in_fifo_push, bus.varint_in_fifo_data);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_overlong();
    int ov0, tr0;
    sb_push(64'd3, 16'd0);
    send_byte(8'h03, 1'b0);
    wait_drain("overlong_pre");
    ov0 = ov_cnt;
    tr0 = tr_cnt;
    for (int i = 0; i < 10; i++) send_byte(8'h80, 1'b0);
    send_byte(8'h00, 1'b0);
    sb_push(64'd7, 16'd1);
    send_byte(8'h07, 1'b1);
    wait_drain("overlong");
    checks++;
    if (ov_cnt != ov0 + 1 || tr_cnt != tr0) begin
      errors++;
      $display("FAIL overlong_pulse: overlong=%0d truncated=%0d new pulses, expected 1,0",
               ov_cnt - ov0, tr_cnt - tr0);
    end
  endtask

  task automatic test_overlong_last();
    int ov0;
    sb_push(64'd1, 16'd0);
    send_byte(8'h01, 1'b0);
    ov0 = ov_cnt;
    for (int i = 0; i < 9; i++) send_byte(8'h80, 1'b0);
    send_byte(8'h80, 1'b1);
    sb_push(64'd5, 16'd0);
    send_byte(8'h05, 1'b1);
    wait_drain("overlong_last");
    checks++;
    if (ov_cnt != ov0 + 1) begin
      errors++;
      $display("FAIL overlong_last_pulse: %0d new overlong pulses, expected 1", ov_cnt - ov0);
    end
  endtask

  task automatic test_truncated();
    int ov0, tr0;
    sb_push(64'd1, 16'd0);
    send_byte(8'h01, 1'b0);
    ov0 = ov_cnt;
    tr0 = tr_cnt;
    send_byte(8'h80, 1'b1);
    sb_push(64'd9, 16'd0);
    send_byte(8'h09, 1'b1);
    wait_drain("truncated");
    checks++;
    if (tr_cnt != tr0 + 1 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL truncated_pulse: truncated=%0d overlong=%0d new pulses, expected 1,0",
               tr_cnt - tr0, ov_cnt - ov0);
    end
  endtask

  task automatic test_reset_mid();
    sb_push(64'd1, 16'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h81, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_partial: busy=%b with partial varint held, expected 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.byte_in_ready !== 1'b1 || bus.varint_in_fifo_push !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b ready=%b push=%b, expected 0,1,0",
               busy, bus.byte_in_ready, bus.varint_in_fifo_push);
    end
    reset = 1'b0;
    sb_push(64'd2, 16'd0);
    send_byte(8'h02, 1'b1);
    wait_drain("reset_mid");
  endtask

  initial begin
    bus.byte_in_data        = 8'h00;
    bus.byte_in_valid       = 1'b0;
    bus.byte_in_last        = 1'b0;
    bus.varint_in_fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_max_len();
    test_backpressure();
    test_overlong();
    test_overlong_last();
    test_truncated();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
